// File: rtl/fpu_int2flt_pipe.sv
// -----------------------------------------------------------------------------
// fpu_int2flt_pipe
// Three-stage pipelined 32-bit integer to IEEE-754 binary32 converter
// (FCVT.S.W / FCVT.S.WU). Rounds to nearest-even and flags inexact results.
// The whole pipe stalls as a unit under downstream backpressure.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operand presented
//   in_ready    pipe can accept an operand this cycle (= advance enable)
//   in_int      32-bit integer operand
//   in_signed   1: two's-complement source, 0: unsigned source
//   in_tag      opaque tag carried alongside the operand
//   out_valid   result available
//   out_ready   consumer accepts the result
//   out_flt     binary32 result
//   out_inexact result was rounded (NX)
//   out_tag     tag belonging to out_flt
// -----------------------------------------------------------------------------
module fpu_int2flt_pipe #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_int,
   input  logic             in_signed,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_flt,
   output logic             out_inexact,
   output logic [TAG_W-1:0] out_tag
);

   // Leading-zero count; an all-zero input reports 31 (its result is
   // overridden by the zero flag in the pack stage anyway).
   function automatic logic [4:0] clz32(input logic [31:0] v);
      logic [4:0] n;
      n = 5'd31;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) begin
            n = 5'(31 - i);
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   // Stage registers
   logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic             sign1_q, sign1_d, zero1_q, zero1_d;
   logic [31:0]      mag1_q, mag1_d;
   logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
   logic             sign2_q, sign2_d, zero2_q, zero2_d;
   logic [7:0]       exp2_q, exp2_d;
   logic [31:0]      norm2_q, norm2_d;
   logic [31:0]      flt3_q, flt3_d;
   logic             nx3_q, nx3_d;

   // Combinational datapath signals
   logic        en_s;
   logic        sign_s, zero_s;
   logic [31:0] mag_s;
   logic [4:0]  lz_s;
   logic [22:0] frac_s;
   logic        guard_s, sticky_s, rup_s;
   logic [23:0] sum_s;
   logic [7:0]  exp_rnd_s;
   logic [31:0] flt_s;
   logic        nx_s;

   assign en_s        = !v3_q || out_ready;
   assign in_ready    = en_s;
   assign out_valid   = v3_q;
   assign out_flt     = flt3_q;
   assign out_inexact = nx3_q;
   assign out_tag     = tag3_q;

   // Stage datapaths: capture/negate, normalize, round/pack
   always_comb begin
      sign_s = in_signed & in_int[31];
      // Negating 0x80000000 wraps to itself, which is the correct magnitude.
      mag_s  = sign_s ? (32'd0 - in_int) : in_int;
      zero_s = (in_int == 32'd0);

      lz_s   = clz32(mag1_q);

      frac_s    = norm2_q[30:8];
      guard_s   = norm2_q[7];
      sticky_s  = |norm2_q[6:0];
      rup_s     = guard_s & (sticky_s | frac_s[0]);
      // A carry out of the mantissa leaves frac at zero and bumps the
      // exponent; the largest exponent reached is 159, so no overflow.
      sum_s     = {1'b0, frac_s} + {23'd0, rup_s};
      exp_rnd_s = exp2_q + {7'd0, sum_s[23]};
      if (zero2_q) begin
         flt_s = 32'd0;
         nx_s  = 1'b0;
      end else begin
         flt_s = {sign2_q, exp_rnd_s, sum_s[22:0]};
         nx_s  = guard_s | sticky_s;
      end
   end

   // Next-state: every stage advances together on en, otherwise holds
   always_comb begin
      v1_d = v1_q;  sign1_d = sign1_q;  zero1_d = zero1_q;
      mag1_d = mag1_q;  tag1_d = tag1_q;
      v2_d = v2_q;  sign2_d = sign2_q;  zero2_d = zero2_q;
      exp2_d = exp2_q;  norm2_d = norm2_q;  tag2_d = tag2_q;
      v3_d = v3_q;  flt3_d = flt3_q;  nx3_d = nx3_q;  tag3_d = tag3_q;
      if (en_s) begin
         v1_d    = in_valid;
         sign1_d = sign_s;
         zero1_d = zero_s;
         mag1_d  = mag_s;
         tag1_d  = in_tag;

         v2_d    = v1_q;
         sign2_d = sign1_q;
         zero2_d = zero1_q;
         exp2_d  = 8'd158 - {3'd0, lz_s};
         norm2_d = mag1_q << lz_s;
         tag2_d  = tag1_q;

         v3_d    = v2_q;
         flt3_d  = flt_s;
         nx3_d   = nx_s;
         tag3_d  = tag2_q;
      end else begin
         v1_d = v1_q;
      end
   end

   // Pipeline state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;  sign1_q <= 1'b0;  zero1_q <= 1'b0;
         mag1_q <= 32'd0;  tag1_q <= '0;
         v2_q <= 1'b0;  sign2_q <= 1'b0;  zero2_q <= 1'b0;
         exp2_q <= 8'd0;  norm2_q <= 32'd0;  tag2_q <= '0;
         v3_q <= 1'b0;  flt3_q <= 32'd0;  nx3_q <= 1'b0;  tag3_q <= '0;
      end else begin
         v1_q <= v1_d;  sign1_q <= sign1_d;  zero1_q <= zero1_d;
         mag1_q <= mag1_d;  tag1_q <= tag1_d;
         v2_q <= v2_d;  sign2_q <= sign2_d;  zero2_q <= zero2_d;
         exp2_q <= exp2_d;  norm2_q <= norm2_d;  tag2_q <= tag2_d;
         v3_q <= v3_d;  flt3_q <= flt3_d;  nx3_q <= nx3_d;  tag3_q <= tag3_d;
      end
   end

endmodule

// File: tb/tb_fpu_int2flt_pipe.sv
// -----------------------------------------------------------------------------
// tb_fpu_int2flt_pipe
// Directed bench for fpu_int2flt_pipe: reset values, single conversions with
// hand-computed results and latency, rounding ties, a back-to-back stream,
// a backpressure stall and an asynchronous reset with work in flight.
// -----------------------------------------------------------------------------
module tb_fpu_int2flt_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_int;
   logic        in_signed;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_flt;
   logic        out_inexact;
   logic [4:0]  out_tag;

   int tests_run;
   int tests_failed;

   fpu_int2flt_pipe #(.TAG_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_int      (in_int),
      .in_signed   (in_signed),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_flt     (out_flt),
      .out_inexact (out_inexact),
      .out_tag     (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   // One isolated conversion: accept edge, then result visible after the
   // third rising edge counting the accept edge.
   task automatic convert(input string name, input logic [31:0] v, input logic sgn,
                          input logic [4:0] tag, input logic [31:0] exp_flt,
                          input logic exp_nx);
      in_int    = v;
      in_signed = sgn;
      in_tag    = tag;
      in_valid  = 1'b1;
      chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk({name, "_lat1"}, {31'd0, out_valid}, 32'd0);
      tick();
      chk({name, "_lat2"}, {31'd0, out_valid}, 32'd0);
      tick();
      chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_flt"}, out_flt, exp_flt);
      chk({name, "_nx"}, {31'd0, out_inexact}, {31'd0, exp_nx});
      chk({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
      tick();
      chk({name, "_drain"}, {31'd0, out_valid}, 32'd0);
   endtask

   logic [31:0] s_flt [8];
   logic [31:0] st_flt [3];
   int idx;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_int    = 32'd0;
      in_signed = 1'b0;
      in_tag    = 5'd0;
      out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_flt", out_flt, 32'd0);
      chk("rst_nx", {31'd0, out_inexact}, 32'd0);
      chk("rst_tag", {27'd0, out_tag}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Basic conversions and boundaries
      convert("s_one",   32'h0000_0001, 1'b1, 5'd1, 32'h3F80_0000, 1'b0);
      convert("s_m1",    32'hFFFF_FFFF, 1'b1, 5'd2, 32'hBF80_0000, 1'b0);
      convert("u_max",   32'hFFFF_FFFF, 1'b0, 5'd3, 32'h4F80_0000, 1'b1);
      convert("s_min",   32'h8000_0000, 1'b1, 5'd4, 32'hCF00_0000, 1'b0);
      convert("s_zero",  32'h0000_0000, 1'b1, 5'd5, 32'h0000_0000, 1'b0);
      convert("u_zero",  32'h0000_0000, 1'b0, 5'd6, 32'h0000_0000, 1'b0);
      convert("tie_dn",  32'h0100_0001, 1'b1, 5'd7, 32'h4B80_0000, 1'b1);
      convert("tie_up",  32'h0100_0003, 1'b1, 5'd8, 32'h4B80_0002, 1'b1);
      convert("carry",   32'h7FFF_FFC0, 1'b1, 5'd9, 32'h4F00_0000, 1'b1);
      convert("u_msb",   32'h8000_0000, 1'b0, 5'd10, 32'h4F00_0000, 1'b0);

      // Back-to-back stream of 1..8, tags 11..18
      s_flt[0] = 32'h3F80_0000; s_flt[1] = 32'h4000_0000;
      s_flt[2] = 32'h4040_0000; s_flt[3] = 32'h4080_0000;
      s_flt[4] = 32'h40A0_0000; s_flt[5] = 32'h40C0_0000;
      s_flt[6] = 32'h40E0_0000; s_flt[7] = 32'h4100_0000;
      idx = 0;
      in_signed = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c < 8) begin
            in_valid = 1'b1;
            in_int   = 32'(c + 1);
            in_tag   = 5'(c + 11);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (out_valid) begin
            if (idx < 8) begin
               chk("strm_cycle", 32'(c), 32'(idx + 2));
               chk("strm_flt", out_flt, s_flt[idx]);
               chk("strm_tag", {27'd0, out_tag}, 32'(idx + 11));
            end else begin
               chk("strm_extra", 32'(idx), 32'd7);
            end
            idx++;
         end
      end
      chk("strm_count", 32'(idx), 32'd8);

      // Stall: 9,10,11 in flight, out_ready low for 5 cycles
      st_flt[0] = 32'h4110_0000; st_flt[1] = 32'h4120_0000; st_flt[2] = 32'h4130_0000;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_int   = 32'(k + 9);
         in_tag   = 5'(k + 21);
         if (k == 2) out_ready = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_flt", out_flt, st_flt[0]);
         chk("stall_tag", {27'd0, out_tag}, 32'd21);
         tick();
      end
      out_ready = 1'b1;
      idx = 0;
      for (int k = 0; k < 6; k++) begin
         if (out_valid) begin
            if (idx < 3) begin
               chk("rel_flt", out_flt, st_flt[idx]);
               chk("rel_tag", {27'd0, out_tag}, 32'(idx + 21));
            end else begin
               chk("rel_extra", 32'(idx), 32'd2);
            end
            idx++;
         end
         tick();
      end
      chk("rel_count", 32'(idx), 32'd3);

      // Asynchronous reset with two conversions in flight
      in_signed = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         in_int   = 32'(k + 12);
         in_tag   = 5'(k + 25);
         tick();
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_flt", out_flt, 32'd0);
      @(posedge clk);
      #4;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("arst_stale", {31'd0, out_valid}, 32'd0);
      end
      convert("post_rst", 32'h0100_0003, 1'b1, 5'd30, 32'h4B80_0002, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
